// File: rtl/riscv32m_div_sequencer.sv
// riscv32m_div_sequencer: iterative RV32M DIV/DIVU/REM/REMU controller with a restoring divider
module riscv32m_div_sequencer #(
  parameter int unsigned STEPS     = 1,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_funct3,
  input  logic [31:0]          cmd_rs1,
  input  logic [31:0]          cmd_rs2,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [31:0]          result_data,
  output logic                 result_error,
  output logic [TAG_WIDTH-1:0] result_tag
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  localparam logic [4:0] ITER_LAST = 5'(32 / STEPS - 1);
  state_t               state_q, state_d;
  logic [31:0]          rs1_q, rs1_d, rs2_q, rs2_d, quo_q, quo_d, div_q, div_d;
  logic [32:0]          rem_q, rem_d;
  logic [2:0]           f3_q, f3_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, res_tag_q, res_tag_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 negq_q, negq_d, negr_q, negr_d, res_err_q, res_err_d;
  logic [31:0]          res_data_q, res_data_d;
  logic                 signed_op;
  logic [32:0]          rem_n;
  logic [31:0]          quo_n;
  assign signed_op    = ~f3_q[0];
  assign cmd_ready    = state_q == IDLE;
  assign result_valid = state_q == DONE;
  assign result_data  = res_data_q;
  assign result_error = res_err_q;
  assign result_tag   = res_tag_q;
  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    for (int i = 0; i < int'(STEPS); i++) begin
      rem_n = {rem_n[31:0], quo_n[31]};
      quo_n = {quo_n[30:0], 1'b0};
      if (rem_n >= {1'b0, div_q}) begin
        rem_n    = rem_n - {1'b0, div_q};
        quo_n[0] = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    tag_d      = tag_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    res_tag_d  = res_tag_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        rs1_d   = cmd_rs1;
        rs2_d   = cmd_rs2;
        f3_d    = cmd_funct3;
        tag_d   = cmd_tag;
        state_d = PREP;
      end
      PREP: begin
        quo_d  = (signed_op && rs1_q[31]) ? -rs1_q : rs1_q;
        div_d  = (signed_op && rs2_q[31]) ? -rs2_q : rs2_q;
        rem_d  = '0;
        cnt_d  = ITER_LAST;
        negq_d = signed_op & (rs1_q[31] ^ rs2_q[31]);
        negr_d = signed_op & rs1_q[31];
        state_d = DONE;
        res_tag_d = tag_q;
        res_err_d = ~f3_q[2];
        // Special cases resolve here; only an ordinary divide falls through to ITER
        if (!f3_q[2]) res_data_d = '0;
        else if (rs2_q == '0) res_data_d = f3_q[1] ? rs1_q : 32'hFFFF_FFFF;
        else if (signed_op && rs1_q == 32'h8000_0000 && rs2_q == 32'hFFFF_FFFF)
          res_data_d = f3_q[1] ? 32'h0 : 32'h8000_0000;
        else begin
          state_d   = ITER;
          res_tag_d = res_tag_q;
          res_err_d = res_err_q;
        end
      end
      ITER: begin
        rem_d   = rem_n;
        quo_d   = quo_n;
        cnt_d   = cnt_q - 5'd1;
        state_d = cnt_q == '0 ? FIX : ITER;
      end
      FIX: begin
        res_data_d = f3_q[1] ? (negr_q ? -rem_q[31:0] : rem_q[31:0]) : (negq_q ? -quo_q : quo_q);
        res_err_d  = 1'b0;
        res_tag_d  = tag_q;
        state_d    = DONE;
      end
      DONE: state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // A killed op must not disturb the visible result registers
    if (flush) begin
      state_d    = IDLE;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      f3_d       = f3_q;
      tag_d      = tag_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      res_tag_d  = res_tag_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      f3_q       <= '0;
      tag_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      tag_q      <= tag_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      res_tag_q  <= res_tag_d;
    end
  end
endmodule

// File: tb/tb_riscv32m_div_sequencer.sv
// tb_riscv32m_div_sequencer: directed and randomized checks on three divider instances (STEPS=1,2,4)
module tb_riscv32m_div_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush [3];
  logic        cmd_valid [3];
  logic        cmd_ready [3];
  logic [2:0]  cmd_funct3 [3];
  logic [31:0] cmd_rs1 [3];
  logic [31:0] cmd_rs2 [3];
  logic [4:0]  cmd_tag [3];
  logic        result_valid [3];
  logic        result_ready [3];
  logic [31:0] result_data [3];
  logic        result_error [3];
  logic [4:0]  result_tag [3];
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv32m_div_sequencer #(.STEPS(1 << g), .TAG_WIDTH(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_funct3(cmd_funct3[g]),
      .cmd_rs1(cmd_rs1[g]), .cmd_rs2(cmd_rs2[g]), .cmd_tag(cmd_tag[g]),
      .result_valid(result_valid[g]), .result_ready(result_ready[g]),
      .result_data(result_data[g]), .result_error(result_error[g]), .result_tag(result_tag[g])
    );
  end
  function automatic logic [32:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    sa = a;
    sb = b;
    if (f3 < 3'd4) return {1'b1, 32'h0};
    if (b == 32'h0) return {1'b0, f3[1] ? a : 32'hFFFF_FFFF};
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, f3[1] ? 32'h0 : 32'h8000_0000};
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, f3[1] ? sr : sq};
    end
    return {1'b0, f3[1] ? a % b : a / b};
  endfunction
  task automatic do_op(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input int bp, output int lat, output logic [31:0] d,
                       output logic e, output logic [4:0] tg);
    cmd_funct3[k] = f3;
    cmd_rs1[k]    = a;
    cmd_rs2[k]    = b;
    cmd_tag[k]    = t;
    cmd_valid[k]  = 1'b1;
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
    lat = 1;
    while (!result_valid[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = result_data[k];
    e  = result_error[k];
    tg = result_tag[k];
    repeat (bp) begin
      @(posedge clk); #1;
    end
    result_ready[k] = 1'b1;
    @(posedge clk); #1;
    result_ready[k] = 1'b0;
  endtask
  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (cmd_ready[k] !== 1'b1 || result_valid[k] !== 1'b0 || result_data[k] !== 32'h0 ||
          result_error[k] !== 1'b0 || result_tag[k] !== 5'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b data=%h err=%b tag=%h, need 1 0 0 0 0",
                 k, cmd_ready[k], result_valid[k], result_data[k], result_error[k], result_tag[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd_funct3[0] = 3'd4; cmd_rs1[0] = 32'd1000; cmd_rs2[0] = 32'd7; cmd_tag[0] = 5'd9;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready[0] !== 1'b1 || result_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_iter: ready=%b valid=%b, need 1 0", cmd_ready[0], result_valid[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (result_valid[0]) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_stale_result: result_valid seen %0d cycles, need 0", seen);
    end
  endtask
  task automatic test_div_signed;
    int lat; logic [31:0] d; logic e; logic [4:0] tg;
    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, lat, d, e, tg);
    n_tests++;
    if (d !== 32'hFFFF_FFFD || tg !== 5'd3 || e !== 1'b0 || lat !== 35) begin
      n_fail++;
      $display("FAIL div_neg7_by_2: data=%h tag=%0d err=%b lat=%0d, need fffffffd 3 0 35", d, tg, e, lat);
    end
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, lat, d, e, tg);
    n_tests++;
    if (d !== 32'hFFFF_FFFF || tg !== 5'd4 || e !== 1'b0 || lat !== 35) begin
      n_fail++;
      $display("FAIL rem_neg7_by_2: data=%h tag=%0d err=%b lat=%0d, need ffffffff 4 0 35", d, tg, e, lat);
    end
  endtask
  task automatic test_special;
    logic [2:0]  f3 [5] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd1};
    logic [31:0] a  [5] = '{32'd123, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd10};
    logic [31:0] b  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] xd [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    logic        xe [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat; logic [31:0] d; logic e; logic [4:0] tg;
    for (int i = 0; i < 5; i++) begin
      do_op(0, f3[i], a[i], b[i], 5'(i + 10), 0, lat, d, e, tg);
      n_tests++;
      if (d !== xd[i] || e !== xe[i] || tg !== 5'(i + 10) || lat !== 2) begin
        n_fail++;
        $display("FAIL special_%0d: data=%h err=%b tag=%0d lat=%0d, need %h %b %0d 2",
                 i, d, e, tg, lat, xd[i], xe[i], i + 10);
      end
    end
  endtask
  task automatic test_backpressure;
    int n;
    cmd_funct3[0] = 3'd5; cmd_rs1[0] = 32'd100; cmd_rs2[0] = 32'd7; cmd_tag[0] = 5'd21;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    n = 0;
    while (!result_valid[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (result_valid[0] !== 1'b1 || cmd_ready[0] !== 1'b0 || result_data[0] !== 32'd14 ||
          result_tag[0] !== 5'd21 || result_error[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: valid=%b ready=%b data=%0d tag=%0d err=%b, need 1 0 14 21 0",
                 i, result_valid[0], cmd_ready[0], result_data[0], result_tag[0], result_error[0]);
      end
      @(posedge clk); #1;
    end
    result_ready[0] = 1'b1;
    @(posedge clk); #1;
    result_ready[0] = 1'b0;
    n_tests++;
    if (result_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b ready=%b, need 0 1", result_valid[0], cmd_ready[0]);
    end
  endtask
  task automatic test_flush;
    int seen;
    cmd_funct3[0] = 3'd4; cmd_rs1[0] = 32'd77; cmd_rs2[0] = 32'd5; cmd_tag[0] = 5'd1;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    n_tests++;
    if (cmd_ready[0] !== 1'b1 || result_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mid_iter: ready=%b valid=%b, need 1 0", cmd_ready[0], result_valid[0]);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid[0]) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_no_result: valid seen %0d cycles, need 0", seen);
    end
    cmd_funct3[0] = 3'd5; cmd_rs1[0] = 32'd9; cmd_rs2[0] = 32'd0;
    cmd_valid[0] = 1'b1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    flush[0] = 1'b0;
    n_tests++;
    if (cmd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_vs_accept: cmd_ready=%b, need 1", cmd_ready[0]);
    end
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result_valid[0]) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_vs_accept_result: valid seen %0d cycles, need 0", seen);
    end
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    @(posedge clk); #1;
    result_ready[0] = 1'b1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    result_ready[0] = 1'b0;
    flush[0] = 1'b0;
    seen = 0;
    repeat (5) begin
      if (result_valid[0]) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 0 || cmd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_vs_handshake: valid seen %0d cycles ready=%b, need 0 1", seen, cmd_ready[0]);
    end
  endtask
  task automatic test_random;
    int lat, exp_lat; logic [31:0] d, a, b; logic e; logic [4:0] tg, t; logic [2:0] f3; logic [32:0] g;
    logic [31:0] pick [5] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 300; i++) begin
        a  = $urandom_range(0, 3) == 0 ? pick[$urandom_range(0, 4)] :
             ($urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 1000)) : $urandom);
        b  = $urandom_range(0, 3) == 0 ? pick[$urandom_range(0, 4)] :
             ($urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 50)) : $urandom);
        f3 = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        t  = 5'($urandom);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        do_op(k, f3, a, b, t, int'($urandom_range(0, 3)), lat, d, e, tg);
        g = golden(f3, a, b);
        exp_lat = (f3 < 3'd4 || b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                  ? 2 : 3 + 32 / (1 << k);
        n_tests++;
        if ({e, d} !== g || tg !== t || lat !== exp_lat) begin
          n_fail++;
          $display("FAIL random_steps%0d f3=%0d a=%h b=%h: err=%b data=%h tag=%0d lat=%0d, need %b %h %0d %0d",
                   1 << k, f3, a, b, e, d, tg, lat, g[32], g[31:0], t, exp_lat);
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; cmd_valid[k] = 1'b0; result_ready[k] = 1'b0;
      cmd_funct3[k] = 3'd0; cmd_rs1[k] = '0; cmd_rs2[k] = '0; cmd_tag[k] = '0;
    end
    test_reset;
    test_div_signed;
    test_special;
    test_backpressure;
    test_flush;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
